// File: rtl/dadda_tree.sv
// Dadda partial-product reduction for six 13-bit Booth rows (weights 4^0..4^5).
// Reduces 6 -> 4 -> 3 -> 2 rows, then a 19-bit carry-propagate add; only the sum is registered.
module dadda_tree (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0][12:0] ops,
   output logic [18:0]      result
);

   localparam int NCOL = 19;
   localparam int NROW = 6;

   logic [18:0] row_a;
   logic [18:0] row_b;
   logic [18:0] sum;

   // Column heights depend only on constants, so this loop nest unrolls into a fixed
   // network of full/half adders; the int bookkeeping folds away in synthesis.
   always_comb begin : reduce
      logic [NROW-1:0] cur [NCOL];
      logic [NROW-1:0] nxt [NCOL];
      int              ch  [NCOL];
      int              nh  [NCOL];
      int              d;
      int              excess;
      int              nfa;
      int              nha;
      int              k;
      int              pos;
      logic            a;
      logic            b;
      logic            cx;

      for (int c = 0; c < NCOL; c++) begin
         cur[c] = '0;
         nxt[c] = '0;
         ch[c]  = 0;
         nh[c]  = 0;
      end
      d      = 0;
      excess = 0;
      nfa    = 0;
      nha    = 0;
      k      = 0;
      pos    = 0;
      a      = 1'b0;
      b      = 1'b0;
      cx     = 1'b0;
      row_a  = '0;
      row_b  = '0;

      // Build the dot matrix; bits that land at column 19 or above are discarded.
      for (int i = 0; i < NROW; i++) begin
         for (int j = 0; j < 13; j++) begin
            pos = 2 * i + j;
            if (pos < NCOL) begin
               cur[pos][ch[pos]] = ops[i][j];
               ch[pos] = ch[pos] + 1;
            end
         end
      end

      for (int s = 0; s < 3; s++) begin
         d = (s == 0) ? 4 : ((s == 1) ? 3 : 2);
         for (int c = 0; c < NCOL; c++) begin
            nxt[c] = '0;
            nh[c]  = 0;
         end
         for (int c = 0; c < NCOL; c++) begin
            // nh[c] holds only the carries arriving from column c-1 at this point.
            excess = ch[c] + nh[c] - d;
            nfa    = 0;
            nha    = 0;
            if (excess > 0) begin
               nfa = excess / 2;
               nha = excess % 2;
            end
            k = 0;
            for (int f = 0; f < 2; f++) begin
               if (f < nfa) begin
                  a  = cur[c][k];
                  b  = cur[c][k+1];
                  cx = cur[c][k+2];
                  nxt[c][nh[c]] = a ^ b ^ cx;
                  nh[c] = nh[c] + 1;
                  if (c < NCOL - 1) begin
                     nxt[c+1][nh[c+1]] = (a & b) | (a & cx) | (b & cx);
                     nh[c+1] = nh[c+1] + 1;
                  end
                  k = k + 3;
               end
            end
            if (nha > 0) begin
               a = cur[c][k];
               b = cur[c][k+1];
               nxt[c][nh[c]] = a ^ b;
               nh[c] = nh[c] + 1;
               if (c < NCOL - 1) begin
                  nxt[c+1][nh[c+1]] = a & b;
                  nh[c+1] = nh[c+1] + 1;
               end
               k = k + 2;
            end
            for (int p = 0; p < NROW; p++) begin
               if (p >= k && p < ch[c]) begin
                  nxt[c][nh[c]] = cur[c][p];
                  nh[c] = nh[c] + 1;
               end
            end
         end
         for (int c = 0; c < NCOL; c++) begin
            cur[c] = nxt[c];
            ch[c]  = nh[c];
         end
      end

      for (int c = 0; c < NCOL; c++) begin
         row_a[c] = cur[c][0];
         row_b[c] = cur[c][1];
      end
   end

   // Carry out of bit 18 is dropped by the 19-bit width.
   assign sum = row_a + row_b;

   always_ff @(posedge clk) begin
      if (!rst) begin
         result <= '0;
      end else begin
         result <= sum;
      end
   end

endmodule

// File: tb/tb_dadda_tree.sv
// Directed and random checks of dadda_tree against a plain weighted-sum reference.
module tb_dadda_tree;

   logic             clk;
   logic             rst;
   logic [5:0][12:0] ops;
   logic [18:0]      result;

   int n_checks;
   int n_pass;

   dadda_tree dut (
      .clk    (clk),
      .rst    (rst),
      .ops    (ops),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [18:0] got, input logic [18:0] exp);
      n_checks = n_checks + 1;
      if (got === exp) begin
         n_pass = n_pass + 1;
      end else begin
         $display("FAIL %s: got 19'h%05h expected 19'h%05h", tag, got, exp);
      end
   endtask

   function automatic logic [18:0] ref_sum(input logic [5:0][12:0] v);
      logic [31:0] acc;
      acc = 32'h0;
      for (int i = 0; i < 6; i++) begin
         acc = acc + (32'(v[i]) << (2 * i));
      end
      return acc[18:0];
   endfunction

   task automatic set_all(input logic [12:0] val);
      for (int i = 0; i < 6; i++) ops[i] = val;
   endtask

   // Drive on the falling edge, check just after the following rising edge.
   task automatic step(input string tag, input logic [18:0] exp);
      @(posedge clk);
      #1;
      check_eq(tag, result, exp);
      @(negedge clk);
   endtask

   initial begin
      logic [5:0][12:0] v;
      int hold;
      n_checks = 0;
      n_pass   = 0;
      rst      = 1'b0;
      ops      = '0;
      @(negedge clk);

      set_all(13'h1FFF);
      step("reset_edge1", 19'h00000);
      step("reset_edge2", 19'h00000);
      rst = 1'b1;
      step("release_full", 19'h29AAB);

      ops = '0;
      step("zero", 19'h00000);

      ops = '0; ops[0] = 13'h0001;
      step("lsb_one", 19'h00001);
      ops = '0; ops[0] = 13'h000F;
      step("lsb_f", 19'h0000F);
      ops = '0; ops[5] = 13'h0001;
      step("msb_one", 19'h00400);
      ops = '0; ops[5] = 13'h1FFF;
      step("msb_trunc", 19'h7FC00);
      ops = '0; ops[2] = 13'h0003;
      step("mid_row", 19'h00030);
      set_all(13'h1FFF);
      step("full_scale", 19'h29AAB);
      step("hold_stable", 19'h29AAB);

      rst = 1'b0;
      step("mid_reset", 19'h00000);
      rst = 1'b1;
      ops = '0; ops[1] = 13'h0001; ops[3] = 13'h0001;
      step("after_reset", 19'h00044);

      for (int n = 0; n < 20; n++) begin
         for (int i = 0; i < 6; i++) v[i] = 13'($urandom);
         ops = v;
         step("b2b", ref_sum(v));
      end

      for (int n = 0; n < 1000; n++) begin
         for (int i = 0; i < 6; i++) v[i] = 13'($urandom);
         ops  = v;
         hold = $urandom_range(1, 3);
         for (int h = 0; h < hold; h++) begin
            step("random", ref_sum(v));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
